// File: rtl/alu_pkg.sv
// Shared definitions for the ALUSystem ALU: function-select opcodes and flag bit positions.
package alu_pkg;

  localparam logic [3:0] ALU_PASSA = 4'b0000;
  localparam logic [3:0] ALU_PASSB = 4'b0001;
  localparam logic [3:0] ALU_NOTA  = 4'b0010;
  localparam logic [3:0] ALU_NOTB  = 4'b0011;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_ADC   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_XOR   = 4'b1001;
  localparam logic [3:0] ALU_LSL   = 4'b1010;
  localparam logic [3:0] ALU_LSR   = 4'b1011;
  localparam logic [3:0] ALU_ASL   = 4'b1100;
  localparam logic [3:0] ALU_ASR   = 4'b1101;
  localparam logic [3:0] ALU_CSL   = 4'b1110;
  localparam logic [3:0] ALU_CSR   = 4'b1111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

endpackage

// File: rtl/alu_unit.sv
// 8-bit ALU: combinational result from FunSel/A/B and the stored carry,
// with a {Z,C,N,O} flag register updated on every rising clock edge.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [3:0]       FunSel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] OutALU,
  output logic [3:0]       OutFlag
);

  logic [WIDTH:0] sumExt;
  logic           carryCur;
  logic           carryNext;
  logic           ovfNext;
  logic [3:0]     flagNext;

  assign carryCur = OutFlag[FLAG_C];

  // Result and next-flag computation; C and O hold unless the op defines them.
  always_comb begin
    OutALU    = A;
    sumExt    = {(WIDTH+1){1'b0}};
    carryNext = carryCur;
    ovfNext   = OutFlag[FLAG_O];
    case (FunSel)
      ALU_PASSA: OutALU = A;
      ALU_PASSB: OutALU = B;
      ALU_NOTA:  OutALU = ~A;
      ALU_NOTB:  OutALU = ~B;
      ALU_ADD: begin
        sumExt    = {1'b0, A} + {1'b0, B};
        OutALU    = sumExt[WIDTH-1:0];
        carryNext = sumExt[WIDTH];
        ovfNext   = (A[WIDTH-1] == B[WIDTH-1]) && (OutALU[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_ADC: begin
        sumExt    = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, carryCur};
        OutALU    = sumExt[WIDTH-1:0];
        carryNext = sumExt[WIDTH];
        ovfNext   = (A[WIDTH-1] == B[WIDTH-1]) && (OutALU[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_SUB: begin
        // Two's-complement subtract: carry-out set means no borrow.
        sumExt    = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        OutALU    = sumExt[WIDTH-1:0];
        carryNext = sumExt[WIDTH];
        ovfNext   = (A[WIDTH-1] != B[WIDTH-1]) && (OutALU[WIDTH-1] != A[WIDTH-1]);
      end
      ALU_AND: OutALU = A & B;
      ALU_OR:  OutALU = A | B;
      ALU_XOR: OutALU = A ^ B;
      ALU_LSL: begin
        OutALU    = {A[WIDTH-2:0], 1'b0};
        carryNext = A[WIDTH-1];
      end
      ALU_LSR: begin
        OutALU    = {1'b0, A[WIDTH-1:1]};
        carryNext = A[0];
      end
      ALU_ASL: begin
        OutALU    = {A[WIDTH-2:0], 1'b0};
        carryNext = A[WIDTH-1];
        ovfNext   = A[WIDTH-1] ^ A[WIDTH-2];
      end
      ALU_ASR: begin
        OutALU    = {A[WIDTH-1], A[WIDTH-1:1]};
        carryNext = A[0];
      end
      ALU_CSL: begin
        OutALU    = {A[WIDTH-2:0], carryCur};
        carryNext = A[WIDTH-1];
      end
      ALU_CSR: begin
        OutALU    = {carryCur, A[WIDTH-1:1]};
        carryNext = A[0];
      end
      default: OutALU = A;
    endcase
    flagNext         = 4'b0000;
    flagNext[FLAG_Z] = (OutALU == {WIDTH{1'b0}});
    flagNext[FLAG_C] = carryNext;
    flagNext[FLAG_N] = OutALU[WIDTH-1];
    flagNext[FLAG_O] = ovfNext;
  end

  // Flag register: synchronous clear, otherwise load every cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OutFlag <= 4'b0000;
    end else begin
      OutFlag <= flagNext;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, hand-written
// reset/mid-cycle sequences, and random ops against an arithmetic reference model.
module tb_alu_unit;

  logic       CLK;
  logic       RST;
  logic [3:0] FunSel;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] OutALU;
  logic [3:0] OutFlag;

  int total = 0;
  int bad   = 0;

  alu_unit #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .FunSel(FunSel), .A(A), .B(B),
    .OutALU(OutALU), .OutFlag(OutFlag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expRes;
    logic [3:0] expFlag;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: integer arithmetic on unsigned/signed interpretations.
  function automatic void refOp(input logic [3:0] op, input int a, input int b,
                                input logic [3:0] fl, output int res, output logic [3:0] nf);
    int  t, sa, sb, s;
    bit  c, o, cin;
    cin = fl[2];
    c   = fl[2];
    o   = fl[0];
    sa  = (a >= 128) ? a - 256 : a;
    sb  = (b >= 128) ? b - 256 : b;
    res = 0;
    case (op)
      4'd0:  res = a;
      4'd1:  res = b;
      4'd2:  res = 255 - a;
      4'd3:  res = 255 - b;
      4'd4, 4'd5: begin
        t   = a + b + ((op == 4'd5) ? int'(cin) : 0);
        res = t % 256;
        c   = (t > 255);
        s   = sa + sb + ((op == 4'd5) ? int'(cin) : 0);
        o   = (s > 127) || (s < -128);
      end
      4'd6: begin
        res = (a - b + 256) % 256;
        c   = (a >= b);
        s   = sa - sb;
        o   = (s > 127) || (s < -128);
      end
      4'd7:  res = a & b;
      4'd8:  res = a | b;
      4'd9:  res = a ^ b;
      4'd10: begin res = (a * 2) % 256; c = (a >= 128); end
      4'd11: begin res = a / 2; c = (a % 2) == 1; end
      4'd12: begin
        res = (a * 2) % 256;
        c   = (a >= 128);
        o   = (sa * 2 > 127) || (sa * 2 < -128);
      end
      4'd13: begin res = a / 2 + ((a >= 128) ? 128 : 0); c = (a % 2) == 1; end
      4'd14: begin res = (a * 2) % 256 + int'(cin); c = (a >= 128); end
      default: begin res = a / 2 + int'(cin) * 128; c = (a % 2) == 1; end
    endcase
    nf = {res == 0, c, res >= 128, o};
  endfunction

  task automatic applyOp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge CLK);
    FunSel = op;
    A      = a;
    B      = b;
    #1;
  endtask

  logic [3:0] modelFlag;
  int         mRes;
  logic [3:0] mFlag;

  initial begin
    RST = 1'b1; FunSel = 4'h0; A = 8'h00; B = 8'h00;
    vecs.push_back(vec_t'{4'h0, 8'hAF, 8'h7D, 8'hAF, 4'b0010});
    vecs.push_back(vec_t'{4'h4, 8'hAF, 8'h7D, 8'h2C, 4'b0100});
    vecs.push_back(vec_t'{4'h5, 8'hAF, 8'h7D, 8'h2D, 4'b0100});
    vecs.push_back(vec_t'{4'h6, 8'hAF, 8'h7D, 8'h32, 4'b0101});
    vecs.push_back(vec_t'{4'h7, 8'hAF, 8'h7D, 8'h2D, 4'b0101});
    vecs.push_back(vec_t'{4'h8, 8'hAF, 8'h7D, 8'hFF, 4'b0111});
    vecs.push_back(vec_t'{4'h9, 8'hAF, 8'h7D, 8'hD2, 4'b0111});
    vecs.push_back(vec_t'{4'h2, 8'hAF, 8'h7D, 8'h50, 4'b0101});
    vecs.push_back(vec_t'{4'h7, 8'h00, 8'h00, 8'h00, 4'b1101});
    vecs.push_back(vec_t'{4'h3, 8'h00, 8'h5A, 8'hA5, 4'b0111});
    vecs.push_back(vec_t'{4'h1, 8'h00, 8'h5A, 8'h5A, 4'b0101});
    vecs.push_back(vec_t'{4'h6, 8'h00, 8'h01, 8'hFF, 4'b0010});
    vecs.push_back(vec_t'{4'hA, 8'h81, 8'h00, 8'h02, 4'b0100});
    vecs.push_back(vec_t'{4'hB, 8'h81, 8'h00, 8'h40, 4'b0100});
    vecs.push_back(vec_t'{4'hD, 8'h81, 8'h00, 8'hC0, 4'b0110});
    vecs.push_back(vec_t'{4'hC, 8'h81, 8'h00, 8'h02, 4'b0101});
    vecs.push_back(vec_t'{4'hE, 8'h81, 8'h00, 8'h03, 4'b0101});
    vecs.push_back(vec_t'{4'hB, 8'h02, 8'h00, 8'h01, 4'b0001});
    vecs.push_back(vec_t'{4'hF, 8'h81, 8'h00, 8'h40, 4'b0101});
    vecs.push_back(vec_t'{4'h5, 8'hF0, 8'h0F, 8'h00, 4'b1100});
    vecs.push_back(vec_t'{4'h4, 8'h7F, 8'h01, 8'h80, 4'b0011});

    // Reset state
    @(posedge CLK); #1;
    check("reset_flags", {4'h0, OutFlag}, 8'h00);
    @(negedge CLK);
    RST = 1'b0;

    // Directed vector table; flags carry over from one vector to the next
    for (int i = 0; i < vecs.size(); i++) begin
      applyOp(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_res", i), OutALU, vecs[i].expRes);
      @(posedge CLK); #1;
      check($sformatf("vec%0d_flag", i), {4'h0, OutFlag}, {4'h0, vecs[i].expFlag});
    end

    // Reset during a carry-producing ADD, then the same op resumes normally
    applyOp(4'h4, 8'hFF, 8'h01);
    RST = 1'b1;
    check("rst_add_res", OutALU, 8'h00);
    @(posedge CLK); #1;
    check("rst_add_flag", {4'h0, OutFlag}, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    check("post_rst_flag", {4'h0, OutFlag}, 8'h0C);

    // Mid-cycle change: only the values present at the edge matter
    applyOp(4'h6, 8'h00, 8'h01);
    #2;
    FunSel = 4'h0; A = 8'h01;
    @(posedge CLK); #1;
    check("midcycle_flag", {4'h0, OutFlag}, 8'h04);

    // Random ops against the reference model
    modelFlag = OutFlag == 4'b0100 ? 4'b0100 : 4'b0100;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      logic [7:0] ra, rb;
      op = 4'($urandom_range(0, 15));
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i % 37 == 0) rb = 8'hFF - ra;
      applyOp(op, ra, rb);
      refOp(op, int'(ra), int'(rb), modelFlag, mRes, mFlag);
      check($sformatf("rnd%0d_op%h_res", i, op), OutALU, 8'(mRes));
      @(posedge CLK); #1;
      check($sformatf("rnd%0d_op%h_flag", i, op), {4'h0, OutFlag}, {4'h0, mFlag});
      modelFlag = mFlag;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
